uart_rx: RTL
============

# uart_rx

16x-oversampling UART receiver for the RS232 master channel. It is the receive-side counterpart of the UART baud clock generator: the generator's 16x `baud_clock` pulse is its only timing reference. The block deserialises one asynchronous character at a time (7/8 data bits, optional parity, one stop bit) into a single-entry holding register with valid/overflow/error flags for the channel controller. Everything runs in the `clk_sys` domain.

## Interface
- No parameters; frame format is selected at run time by ports.
- `clk_sys` in 1: system clock.
- `rst_sys_n` in 1: reset. Asynchronous, active-low.
- `baud_clock` in 1: 16x baud tick, one `clk_sys` cycle wide, from the baud clock generator.
- `rx` in 1: serial line, asynchronous, idle high.
- `bit8` in 1: 1 = 8 data bits, 0 = 7 data bits.
- `parity_en` in 1: 1 = parity bit present after data.
- `odd_n_even` in 1: 1 = odd parity, 0 = even parity.
- `read_rx_byte` in 1: one-cycle pulse from the consumer that consumes the held byte.
- `rx_data` out 8: received byte, LSB first on the line. Bit 7 = 0 in 7-bit mode.
- `rx_valid` out 1: the holding register contains an unread byte.
- `parity_err` out 1: parity mismatch on the held byte.
- `framing_err` out 1: stop bit sampled low on the held byte.
- `overflow` out 1: sticky flag. A completed byte was discarded because `rx_valid` was still set.

## Operation
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1. All decisions use the synchronised value `rx_s`.
- State and counters advance only on cycles where `baud_clock`=1. On all other cycles they hold.
- States: IDLE, START, DATA, PARITY, STOP. There is a 4-bit tick counter `tcnt` and a 3-bit bit index `bcnt`.
- **IDLE:** on a tick with `rx_s`=0, go to START with `tcnt`=0.
- **START:** `tcnt` increments on each tick. On the tick where `tcnt`=7 (mid start bit):
  - if `rx_s`=0, go to DATA with `tcnt`=0 and `bcnt`=0;
  - otherwise treat it as a glitch and return to IDLE.
- **DATA:** `tcnt` increments and wraps 15→0. On each tick where `tcnt`=15, shift `rx_s` into the shift register (LSB first) and increment `bcnt`.
  - After the last bit (bit 7, or bit 6 when `bit8`=0), go to PARITY if `parity_en`=1, else go to STOP.
- **PARITY:** on the tick where `tcnt`=15, sample the parity bit.
  - Expected value is the XOR of the data bits, XOR `odd_n_even`.
  - Go to STOP.
- **STOP:** on the tick where `tcnt`=15, sample the stop bit and complete the frame.
  - If `rx_valid`=0, or `read_rx_byte`=1 in the same cycle: load `rx_data`, `parity_err` (0 when parity is disabled) and `framing_err` (= !`rx_s`), and set `rx_valid`=1.
  - Otherwise discard the new byte. `rx_data` and the error flags keep the old byte's values, and `overflow` is set.
  - Return to IDLE either way. A low stop bit also returns to IDLE, so the next start is detected on a following tick with `rx_s`=0.
- `read_rx_byte` while `rx_valid`=1 and no byte is completing: clear `rx_valid` and `overflow`. `rx_data` and the error flags hold.
- `read_rx_byte` while `rx_valid`=0: no effect.
- Format inputs are treated as static during a frame. Changing them mid-frame has undefined effect on that frame only.
- Reset mid-frame: immediately return to IDLE. All outputs go to 0 and the shift register is cleared.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `parity_err`=0, `framing_err`=0, `overflow`=0, state IDLE.
- Let the detection tick be T0, the first tick with `rx_s`=0 in IDLE.
  - Start check: tick T0+8.
  - Data bit k: tick T0+8+16(k+1).
  - Parity: tick T0+8+16(N+1), where N is the number of data bits.
  - Stop: tick T0+8+16(N+1+P), where P = `parity_en`.
- `rx_valid` and the flags update on the `clk_sys` edge that ends the stop-sample tick cycle. The holding register adds no further delay.
- Input latency is 2 `clk_sys` cycles of synchroniser, plus up to one tick of detection uncertainty.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (`UART_RX_IDLE` through `UART_RX_STOP`);
  - `UART_OVERSAMPLE`=16 and `UART_MID_SAMPLE`=7;
  - the data-width constants.
  
  The transmitter uses the same package.
- One natural sub-module: `uart_rx_sync`, the 2-flop synchroniser with a reset value of 1. Everything else stays in one FSM module.

## Test plan
Benches drive `baud_val`=3 on the clock generator, giving a tick every 4 `clk_sys` cycles, and an `rx` bit period of 64 cycles.
- **8N1 byte:** send 0xA5 → `rx_data`=0xA5, `rx_valid`=1, no errors. Pulse `read_rx_byte` → `rx_valid`=0.
- **8E1 parity:** send 0x3C with parity bit 0 → no errors. Send 0x3C with parity bit 1 → `parity_err`=1, `rx_data`=0x3C.
- **7O1, stop bit 0:** send 0x55 in 7-bit mode with the stop bit forced low → `rx_data`=0x55, `framing_err`=1. Then a normal 0x12 frame → `framing_err`=0.
- **Start glitch:** drive `rx` low for 3 ticks, then high → no `rx_valid`, FSM back in IDLE. The next valid 0x81 frame is received correctly.
- **Overflow:** send 0x11 then 0x22 with no read → `rx_data`=0x11, `overflow`=1. Read → `overflow`=0.
  - Repeat with `read_rx_byte` pulsed in the stop-sample cycle of the second frame → `rx_data`=0x22, `rx_valid`=1, `overflow`=0.
- **Reset mid-frame:** assert `rst_sys_n` during data bit 3 → all outputs 0 immediately. After release, 0xF0 is received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: receiver state encoding, oversampling and data widths.
package uart_pkg;

   localparam int unsigned UART_STATE_W    = 3;
   localparam int unsigned UART_TCNT_W     = 4;
   localparam int unsigned UART_BCNT_W     = 3;
   localparam int unsigned UART_DATA_W     = 8;
   localparam int unsigned UART_DATA7_W    = 7;
   localparam int unsigned UART_OVERSAMPLE = 16;
   localparam int unsigned UART_MID_SAMPLE = 7;

   localparam logic [UART_STATE_W-1:0] UART_RX_IDLE   = 3'd0;
   localparam logic [UART_STATE_W-1:0] UART_RX_START  = 3'd1;
   localparam logic [UART_STATE_W-1:0] UART_RX_DATA   = 3'd2;
   localparam logic [UART_STATE_W-1:0] UART_RX_PARITY = 3'd3;
   localparam logic [UART_STATE_W-1:0] UART_RX_STOP   = 3'd4;

   // Keep only the bits that belong to the character (bit 7 forced low in 7-bit mode).
   function automatic logic [UART_DATA_W-1:0] uart_mask_data(input logic [UART_DATA_W-1:0] d,
                                                             input logic bit8);
      return bit8 ? d : {1'b0, d[UART_DATA7_W-1:0]};
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
module uart_rx_sync (
   input  logic clk_sys,
   input  logic rst_sys_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Resynchronise d into clk_sys; both stages come out of reset at line-idle (1).
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with a single-entry holding register.
module uart_rx
   import uart_pkg::*;
(
   input  logic       clk_sys,
   input  logic       rst_sys_n,
   input  logic       baud_clock,
   input  logic       rx,
   input  logic       bit8,
   input  logic       parity_en,
   input  logic       odd_n_even,
   input  logic       read_rx_byte,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       framing_err,
   output logic       overflow
);

   localparam logic [UART_TCNT_W-1:0] TCNT_LAST = UART_TCNT_W'(UART_OVERSAMPLE - 1);
   localparam logic [UART_TCNT_W-1:0] TCNT_MID  = UART_TCNT_W'(UART_MID_SAMPLE);
   localparam logic [UART_BCNT_W-1:0] BCNT_L8   = UART_BCNT_W'(UART_DATA_W - 1);
   localparam logic [UART_BCNT_W-1:0] BCNT_L7   = UART_BCNT_W'(UART_DATA7_W - 1);

   logic                    rx_s;
   logic [UART_STATE_W-1:0] state_q, state_d;
   logic [UART_TCNT_W-1:0]  tcnt_q, tcnt_d;
   logic [UART_BCNT_W-1:0]  bcnt_q, bcnt_d;
   logic [UART_DATA_W-1:0]  shreg_q, shreg_d;
   logic                    par_err_q, par_err_d;
   logic [UART_DATA_W-1:0]  data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    perr_q, perr_d;
   logic                    ferr_q, ferr_d;
   logic                    ovf_q, ovf_d;

   logic [UART_DATA_W-1:0]  char_c;
   logic                    mid_tick_c;
   logic                    last_bit_c;

   uart_rx_sync u_sync (
      .clk_sys   (clk_sys),
      .rst_sys_n (rst_sys_n),
      .d         (rx),
      .q         (rx_s)
   );

   assign char_c     = uart_mask_data(shreg_q, bit8);
   assign mid_tick_c = (tcnt_q == TCNT_LAST);
   assign last_bit_c = bit8 ? (bcnt_q == BCNT_L8) : (bcnt_q == BCNT_L7);

   // Next-state, counters, shift register and holding-register update.
   always_comb begin
      state_d   = state_q;
      tcnt_d    = tcnt_q;
      bcnt_d    = bcnt_q;
      shreg_d   = shreg_q;
      par_err_d = par_err_q;
      data_d    = data_q;
      valid_d   = valid_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      ovf_d     = ovf_q;

      // A consumer read drops the held byte; a completing frame below may refill it.
      if (read_rx_byte && valid_q) begin
         valid_d = 1'b0;
         ovf_d   = 1'b0;
      end

      if (baud_clock) begin
         case (state_q)
            UART_RX_IDLE: begin
               if (!rx_s) begin
                  state_d = UART_RX_START;
                  tcnt_d  = '0;
               end
            end
            UART_RX_START: begin
               tcnt_d = tcnt_q + UART_TCNT_W'(1);
               if (tcnt_q == TCNT_MID) begin
                  if (!rx_s) begin
                     state_d = UART_RX_DATA;
                     tcnt_d  = '0;
                     bcnt_d  = '0;
                     shreg_d = '0;
                  end else begin
                     state_d = UART_RX_IDLE;
                  end
               end
            end
            UART_RX_DATA: begin
               tcnt_d = tcnt_q + UART_TCNT_W'(1);
               if (mid_tick_c) begin
                  shreg_d[bcnt_q] = rx_s;
                  bcnt_d          = bcnt_q + UART_BCNT_W'(1);
                  if (last_bit_c) begin
                     state_d = parity_en ? UART_RX_PARITY : UART_RX_STOP;
                  end
               end
            end
            UART_RX_PARITY: begin
               tcnt_d = tcnt_q + UART_TCNT_W'(1);
               if (mid_tick_c) begin
                  par_err_d = rx_s ^ (^char_c) ^ odd_n_even;
                  state_d   = UART_RX_STOP;
               end
            end
            UART_RX_STOP: begin
               tcnt_d = tcnt_q + UART_TCNT_W'(1);
               if (mid_tick_c) begin
                  state_d = UART_RX_IDLE;
                  if (!valid_q || read_rx_byte) begin
                     data_d  = char_c;
                     perr_d  = parity_en & par_err_q;
                     ferr_d  = !rx_s;
                     valid_d = 1'b1;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
            end
            default: state_d = UART_RX_IDLE;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         state_q   <= UART_RX_IDLE;
         tcnt_q    <= '0;
         bcnt_q    <= '0;
         shreg_q   <= '0;
         par_err_q <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tcnt_q    <= tcnt_d;
         bcnt_q    <= bcnt_d;
         shreg_q   <= shreg_d;
         par_err_q <= par_err_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         ovf_q     <= ovf_d;
      end
   end

   assign rx_data     = data_q;
   assign rx_valid    = valid_q;
   assign parity_err  = perr_q;
   assign framing_err = ferr_q;
   assign overflow    = ovf_q;

endmodule
